// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers x/y and timing lock from a 640x480@60 hsync/vsync stream.
// Define VGA_RX_STATS_EN to add the frame_cnt/err_cnt statistics outputs.
module vga_sync_rx #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        locked,
`ifdef VGA_RX_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        err
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  X_HS     = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]  X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]  Y_VS     = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]  Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_VIS    = 10'(V_DISPLAY);
    localparam logic [10:0] LEN_GOOD = 11'(H_TOTAL);
    localparam logic [10:0] LEN_TMO  = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  CNT_GOOD = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t      state, state_n;
    logic [3:0]  good_frames, good_n;
    logic        skip_chk, skip_n;
    logic        viol;

    logic        hsync_q, vs_last;
    logic [10:0] line_len;
    logic [9:0]  line_cnt;
    logic [9:0]  x_n, y_n;
    logic        err_n, locked_n, video_n;

    logic hs_fall, vs_fall, line_bad, frame_bad, timeout;

    assign hs_fall   = p_tick && hsync_q && !hsync;
    assign vs_fall   = hs_fall && vs_last && !vsync;
    assign line_bad  = hs_fall && (line_len != LEN_GOOD);
    assign frame_bad = vs_fall && (line_cnt != CNT_GOOD);
    // a missing hsync is declared once the meter would reach two full lines
    assign timeout   = p_tick && !hs_fall && (line_len == LEN_TMO);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SEARCH;
            good_frames <= '0;
            skip_chk    <= 1'b0;
        end else begin
            state       <= state_n;
            good_frames <= good_n;
            skip_chk    <= skip_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_frames;
        skip_n  = skip_chk && !hs_fall;
        viol    = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                    skip_n  = 1'b1;
                end
            end
            ACQUIRE: begin
                // the line meter is not aligned until one full line has passed
                if (line_bad && !skip_chk) begin
                    viol    = 1'b1;
                    state_n = SEARCH;
                end else if (frame_bad) begin
                    viol   = 1'b1;
                    good_n = '0;
                end else if (vs_fall) begin
                    good_n = good_frames + 4'd1;
                    if (good_n == LOCK_N) begin
                        state_n = LOCKED;
                    end
                end else if (timeout) begin
                    viol    = 1'b1;
                    state_n = SEARCH;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || timeout) begin
                    viol    = 1'b1;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_comb begin
        x_n = x;
        y_n = y;
        if (p_tick) begin
            if (hs_fall) begin
                x_n = X_HS;
            end else if (x == X_MAX) begin
                x_n = '0;
            end else begin
                x_n = x + 10'd1;
            end
            if (vs_fall) begin
                y_n = Y_VS;
            end else if (!hs_fall && (x == X_MAX)) begin
                y_n = (y == Y_MAX) ? 10'd0 : y + 10'd1;
            end
        end
    end

    always_comb begin
        err_n    = viol;
        locked_n = (state_n == LOCKED);
        video_n  = locked_n && (x_n < X_VIS) && (y_n < Y_VIS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_q  <= 1'b1;
            vs_last  <= 1'b1;
            line_len <= '0;
            line_cnt <= '0;
            x        <= '0;
            y        <= '0;
            err      <= 1'b0;
            locked   <= 1'b0;
            video_on <= 1'b0;
        end else begin
            x        <= x_n;
            y        <= y_n;
            err      <= err_n;
            locked   <= locked_n;
            video_on <= video_n;
            if (p_tick) begin
                hsync_q <= hsync;
                if (hs_fall) begin
                    line_len <= 11'd1;
                end else if (line_len != 11'h7FF) begin
                    line_len <= line_len + 11'd1;
                end
            end
            if (hs_fall) begin
                vs_last <= vsync;
                if (vs_fall) begin
                    line_cnt <= 10'd1;
                end else if (line_cnt != 10'h3FF) begin
                    line_cnt <= line_cnt + 10'd1;
                end
            end
        end
    end

`ifdef VGA_RX_STATS_EN
    logic count_frame;

    assign count_frame = vs_fall && (state == LOCKED) && (state_n == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (count_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (viol && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: randomized scoreboard bench for vga_sync_rx on reduced timing.
// A tick-level reference model predicts every registered output of the receiver.
`timescale 1ns/1ps
module tb_vga_sync_rx;

    localparam int HD = 10, HF = 2, HSY = 2, HB = 2;
    localparam int VD = 8, VF = 1, VSY = 2, VB = 1;
    localparam int LF = 2;
    localparam int HT = HD + HF + HSY + HB;
    localparam int VT = VD + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int M_SRCH = 0, M_ACQ = 1, M_LCK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] x, y;
    logic       video_on, locked, err;
`ifdef VGA_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    vga_sync_rx #(
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .hsync(hsync),
        .vsync(vsync),
        .x(x),
        .y(y),
        .video_on(video_on),
        .locked(locked),
`ifdef VGA_RX_STATS_EN
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit lk;
        bit vo;
        bit er;
        int fc;
        int ec;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails = 0;
    int   dut_errs = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // reference model: unbounded integer view of the receive rules
    int m_mode, m_good, m_len, m_lines, m_x, m_y, m_frames, m_errs;
    bit m_hs_q, m_vs_hf, m_fresh;

    task automatic push_exp(input bit bad);
        exp_t e;
        e.x  = m_x;
        e.y  = m_y;
        e.lk = (m_mode == M_LCK);
        e.vo = e.lk && (m_x < HD) && (m_y < VD);
        e.er = bad;
        e.fc = m_frames % 65536;
        e.ec = (m_errs > 255) ? 255 : m_errs;
        sbq.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = M_SRCH; m_good = 0; m_len = 0; m_lines = 0;
        m_x = 0; m_y = 0; m_frames = 0; m_errs = 0;
        m_hs_q = 1'b1; m_vs_hf = 1'b1; m_fresh = 1'b0;
    endtask

    task automatic model_tick(input bit hs, input bit vs);
        bit hf, vf, bad, fresh_now, long_gap;
        hf = m_hs_q && !hs;
        vf = hf && m_vs_hf && !vs;
        long_gap = !hf && (m_len + 1 == 2 * HT);
        fresh_now = m_fresh;
        if (hf) m_fresh = 1'b0;
        bad = 1'b0;
        if (m_mode == M_SRCH) begin
            if (vf) begin
                m_mode = M_ACQ; m_good = 0; m_fresh = 1'b1;
            end
        end else if (m_mode == M_ACQ) begin
            if (hf && !fresh_now && m_len != HT) begin
                bad = 1'b1; m_mode = M_SRCH;
            end else if (vf && m_lines != VT) begin
                bad = 1'b1; m_good = 0;
            end else if (vf) begin
                m_good++;
                if (m_good >= LF) m_mode = M_LCK;
            end else if (long_gap) begin
                bad = 1'b1; m_mode = M_SRCH;
            end
        end else begin
            if ((hf && m_len != HT) || (vf && m_lines != VT) || long_gap) begin
                bad = 1'b1; m_mode = M_SRCH;
            end else if (vf) begin
                m_frames++;
            end
        end
        if (bad) m_errs++;
        m_len = hf ? 1 : m_len + 1;
        if (hf) begin
            m_lines = vf ? 1 : m_lines + 1;
            m_vs_hf = vs;
        end
        m_hs_q = hs;
        if (hf) begin
            m_x = HD + HF;
        end else begin
            m_x = (m_x + 1) % HT;
            if (m_x == 0) m_y = (m_y + 1) % VT;
        end
        if (vf) m_y = VD + VF;
        push_exp(bad);
    endtask

    // monitor: one expectation per pixel tick or reset clock
    logic rs_s, tk_s;
    always @(posedge clk) begin
        rs_s = reset;
        tk_s = p_tick;
        #1;
        if (mon_on) begin
            if (err === 1'b1) dut_errs++;
            if (!rs_s || tk_s) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("x", x, e.x);
                    check("y", y, e.y);
                    check("locked", locked, e.lk);
                    check("video_on", video_on, e.vo);
                    check("err", err, e.er);
`ifdef VGA_RX_STATS_EN
                    check("frame_cnt", frame_cnt, e.fc);
                    check("err_cnt", err_cnt, e.ec);
`endif
                end
            end else begin
                check("err_width", err, 0);
            end
        end
    end

    // source stream
    int sx, sy, hold_hi;
    bit short_px, skip_ln, alt_vs;

    task automatic pix(input bit hs, input bit vs);
        @(negedge clk);
        p_tick = 1'b1;
        hsync = hs;
        vsync = vs;
        model_tick(hs, vs);
        @(negedge clk);
        p_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic src_step();
        bit hs, vs;
        hs = !(sx >= HD + HF && sx < HD + HF + HSY);
        if (alt_vs) vs = ((sy % 2) == 0);
        else vs = !(sy >= VD + VF && sy < VD + VF + VSY);
        if (hold_hi > 0) begin
            hs = 1'b1;
            hold_hi--;
        end
        pix(hs, vs);
        sx++;
        if (short_px && sx == 2) begin
            sx = 3;
            short_px = 1'b0;
        end
        if (sx == HT) begin
            sx = 0;
            sy++;
            if (skip_ln && sy == 3) begin
                sy = 4;
                skip_ln = 1'b0;
            end
            if (sy == VT) sy = 0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            p_tick = 1'b0;
            mon_on = 1'b1;
            model_reset();
            push_exp(1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic random_start();
        sx = $urandom_range(0, HD - 1);
        sy = $urandom_range(0, VD - 1);
    endtask

    task automatic run(input int n);
        repeat (n) src_step();
    endtask

    task automatic run_until_locked(input string name, input int limit);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < limit) begin
            src_step();
            n++;
        end
        check(name, locked, 1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0, ofs;
        hold_hi = 0; short_px = 1'b0; skip_ln = 1'b0; alt_vs = 1'b0;
        do_reset(3);
        check("rst_x", x, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);

        // lock from a random starting point in the visible area
        random_start();
        ofs = ((VD + VF) * HT + HD + HF) - (sy * HT + sx);
        n = 0;
        while (locked !== 1'b1 && n < 4 * FRAME) begin
            src_step();
            n++;
        end
        check("lock_latency", n, ofs + 1 + 2 * FRAME);

        n = 0;
        while (!(sx == 0 && sy == 0) && n < FRAME) begin
            src_step();
            n++;
        end
        src_step();
        check("origin_x", x, 0);
        check("origin_y", y, 0);
        check("origin_video", video_on, 1);
        run(FRAME);

        // one short line while locked
        short_px = 1'b1;
        e0 = dut_errs;
        run(2 * HT);
        check("short_line_errs", dut_errs - e0, 1);
        check("short_line_unlock", locked, 0);
        run_until_locked("relock_short", 4 * FRAME);

        // hsync stuck high past the timeout
        hold_hi = 2 * HT + 4;
        e0 = dut_errs;
        run(3 * HT);
        check("timeout_errs", dut_errs - e0, 1);
        check("timeout_unlock", locked, 0);

        // short frame while acquiring
        n = 0;
        while (m_mode != M_ACQ && n < 2 * FRAME) begin
            src_step();
            n++;
        end
        skip_ln = 1'b1;
        e0 = dut_errs;
        n = 0;
        while (locked !== 1'b1 && n < 4 * FRAME) begin
            src_step();
            n++;
        end
        check("acq_short_frame_errs", dut_errs - e0, 1);
        check("acq_lock_ticks", n, (3 * VT - 1) * HT);

        // reset pulse mid-line while locked
        n = 0;
        while (!(sx == 5 && sy < VD) && n < FRAME) begin
            src_step();
            n++;
        end
        do_reset(1);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_locked", locked, 0);
        check("midrst_video", video_on, 0);
        run_until_locked("relock_reset", 4 * FRAME);

        // random glitches on the line stream
        for (int i = 0; i < 6 * VT; i++) begin
            case ($urandom_range(0, 7))
                0: short_px = 1'b1;
                1: hold_hi = $urandom_range(1, 40);
                default: ;
            endcase
            run(HT);
        end
        short_px = 1'b0;
        hold_hi = 0;
        run_until_locked("relock_random", 5 * FRAME);

`ifdef VGA_RX_STATS_EN
        do_reset(2);
        random_start();
        run_until_locked("stats_lock", 4 * FRAME);
        n = 0;
        while (m_frames < 3 && n < 5 * FRAME) begin
            src_step();
            n++;
        end
        check("stats_frames3", frame_cnt, 3);
        alt_vs = 1'b1;
        n = 0;
        while (m_errs < 300 && n < 700 * HT) begin
            src_step();
            n++;
        end
        run(HT);
        check("stats_err_sat", err_cnt, 255);
        check("stats_frames_hold", frame_cnt, 3);
        alt_vs = 1'b0;
`endif

        repeat (8) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
